// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                          fsm_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            done,
    output logic                          err,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          ctrl_busy,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_busy
);

    localparam int GID_W = $clog2(NUM_REQ);
    localparam int TMAX  = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t                 state, state_nx;
    logic [TW-1:0]          timer, timer_nx;
    logic [GID_W-1:0]       last, last_nx;
    logic [GID_W-1:0]       grant_nx;
    logic [GID_W-1:0]       win, idx;
    logic                   found;
    logic [NUM_REQ-1:0]     ack_nx, done_nx;
    logic                   err_nx, start_nx;
    logic [DATA_WIDTH-1:0]  data_nx;
    logic [DATA_WIDTH-1:0]  req_bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search starts just after the last winner so the previous grantee ranks lowest.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GID_W'((int'(last) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        last_nx  = last;
        grant_nx = grant_id;
        data_nx  = tx_data;
        ack_nx   = '0;
        done_nx  = '0;
        err_nx   = 1'b0;
        start_nx = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    data_nx      = req_bytes[win];
                    grant_nx     = win;
                    last_nx      = win;
                    ack_nx[win]  = 1'b1;
                    start_nx     = 1'b1;
                    timer_nx     = '0;
                    state_nx     = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // A busy rise on the limit cycle still counts as a successful launch.
                if (tx_busy) begin
                    state_nx = WAIT_DONE;
                end else if (timer == TO_LAST) begin
                    err_nx   = 1'b1;
                    timer_nx = '0;
                    state_nx = GAP;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_nx[grant_id] = 1'b1;
                    timer_nx          = '0;
                    state_nx          = GAP;
                end
            end
            GAP: begin
                if (timer == GAP_LAST) begin
                    timer_nx = '0;
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge fsm_clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            last     <= GID_W'(NUM_REQ - 1);
            grant_id <= '0;
            tx_data  <= '0;
            ack      <= '0;
            done     <= '0;
            err      <= 1'b0;
            tx_start <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            last     <= last_nx;
            grant_id <= grant_nx;
            tx_data  <= data_nx;
            ack      <= ack_nx;
            done     <= done_nx;
            err      <= err_nx;
            tx_start <= start_nx;
        end
    end

    assign ctrl_busy = (state != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter among NUM_REQ byte requesters.
- Accepts one byte per grant and launches the transmitter with a single-cycle start pulse.
- Tracks the transmitter's busy window, reports completion or timeout back to the granted requester, then enforces an inter-frame gap.
- Sits between client logic (CPU regs, debug port, etc.) and the transmitter datapath/FSM.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width passed to transmitter
GAP_CYCLES, 2, idle cycles enforced after each frame (>=1)
TIMEOUT, 15, max cycles to wait for tx_busy rise after tx_start (>=1)

Ports:
fsm_clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
req  input  NUM_REQ  per-requester transfer request; held until ack
req_data  input  NUM_REQ*DATA_WIDTH  request byte; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
ack  output  NUM_REQ  one-hot 1-cycle pulse: byte latched, requester may drop req/change data
done  output  NUM_REQ  one-hot 1-cycle pulse: frame for that requester completed
err  output  1  1-cycle pulse: transmitter failed to assert tx_busy within TIMEOUT
grant_id  output  clog2(NUM_REQ)  index of current/last granted requester
ctrl_busy  output  1  high whenever state != IDLE
tx_start  output  1  1-cycle launch pulse to transmitter
tx_data  output  DATA_WIDTH  byte to transmitter; stable from tx_start until next grant
tx_busy  input  1  transmitter busy flag

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; ack, done, err, tx_start=0; tx_data=0; grant_id=0; timers=0; round-robin pointer last=NUM_REQ-1, so req[0] has highest priority first. Reset mid-frame aborts silently, with no done/err pulse.
- All outputs registered; ctrl_busy is decoded from the registered state.
- States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE
  - req sampled only here.
  - If any req bit set, pick winner w = first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - Next edge: tx_data<=req_data[w]; grant_id<=w; last<=w; ack[w]<=1; tx_start<=1; timer<=0; state->WAIT_BUSY.
  - Latency: req high in cycle n -> ack/tx_start high in cycle n+1.
  - No req: stay IDLE; outputs other than pulses hold.
- WAIT_BUSY
  - Pulses self-clear after one cycle.
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise timer increments; when timer==TIMEOUT-1 and tx_busy=0 -> err<=1, state->GAP, no done.
  - tx_busy=1 in the same cycle as the limit wins: go WAIT_DONE.
- WAIT_DONE
  - Stays while tx_busy=1; no timeout.
  - tx_busy=0 -> done[grant_id]<=1, timer<=0, state->GAP.
- GAP
  - Exactly GAP_CYCLES cycles in GAP, then IDLE.
  - req ignored during GAP.
- Fairness:
  - A continuously requesting requester waits at most NUM_REQ-1 grants.
  - Same requester may be regranted immediately only if no other req is set.
- Requester contract:
  - Dropping req before ack: no grant, no ack.
  - Holding req after ack: treated as a new request at next IDLE.
- tx_busy glitch high while in IDLE or GAP is ignored.
- Timer width clog2(max(TIMEOUT, GAP_CYCLES)+1).
- Only one of ack/done/err bits is ever high per cycle.

Test Plan:
1. Reset, then req=0001, data0=0x55, transmitter model raises busy 2 cycles after start for 10 cycles -> ack=0001 and tx_start one cycle after req, tx_data=0x55; done=0001 one cycle after busy falls; ctrl_busy low after GAP_CYCLES=2 cycles.
2. req=1111 held continuously, data i=0xA0+i -> grant order 0,1,2,3,0; tx_data sequence A0,A1,A2,A3,A0; each done matches grant_id.
3. Transmitter model never raises busy -> err pulses exactly TIMEOUT cycles after tx_start cycle; no done; next grant accepted after gap.
4. req[2] asserted alone, dropped during WAIT_DONE of a req[1] frame -> no ack[2]; only requester 1 completes.
5. rst asserted while in WAIT_DONE -> next cycle all outputs 0, state IDLE, no done; subsequent req=0010 with last reset to 3 grants requester 1 correctly, and req=0011 grants requester 0 first.
6. tx_busy rises on the same cycle timer hits the limit -> no err, proceeds to WAIT_DONE and completes with done.
